tx_mac_sched: RTL and testbench



---
 rtl/tx_mac_sched_if.sv | 28 ++
 rtl/tx_mac_sched.sv | 150 +++++++++++++++
 tb/tb_tx_mac_sched.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_mac_sched_if.sv
// Scheduler bus: requester-side request/ack signals plus the Tx MAC start/done handshake.
// The scheduler takes the slave modport; requesters and the MAC model take master.
interface tx_mac_sched_if #(
  parameter int unsigned NReq = 4,
  parameter int unsigned Aw   = 10
);
  logic               enable;
  logic [NReq-1:0]    req;
  logic [NReq*Aw-1:0] req_addr;
  logic [NReq-1:0]    ack;
  logic               ack_err;
  logic [Aw-1:0]      buf_start_addr;
  logic               tx_mac_start;
  logic               tx_mac_done;
  logic               busy;
  logic [2:0]         cur_grant;
  logic [7:0]         timeout_count;

  modport master (
    output enable, req, req_addr, tx_mac_done,
    input  ack, ack_err, buf_start_addr, tx_mac_start, busy, cur_grant, timeout_count
  );

  modport slave (
    input  enable, req, req_addr, tx_mac_done,
    output ack, ack_err, buf_start_addr, tx_mac_start, busy, cur_grant, timeout_count
  );
endinterface

// File: rtl/tx_mac_sched.sv
// Round-robin scheduler sharing the Tx MAC packet engine among NReq buffer-resident sources,
// with a launch watchdog and an enforced idle gap between launches.
module tx_mac_sched #(
  parameter int unsigned NReq   = 4,
  parameter int unsigned Aw     = 10,
  parameter int unsigned ToBits = 16,
  parameter int unsigned Gap    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tx_mac_sched_if.slave bus_io
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLaunch  = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;
  localparam logic [1:0] StGap     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        last_q, last_d;
  logic [Aw-1:0]     addr_q, addr_d;
  logic [ToBits-1:0] wd_q, wd_d;
  logic [7:0]        gap_q, gap_d;
  logic [NReq-1:0]   ack_q, ack_d;
  logic              ack_err_q, ack_err_d;
  logic [7:0]        to_cnt_q, to_cnt_d;

  logic          any_req, hi_found;
  logic [2:0]    hi_idx, lo_idx, sel_idx;
  logic [Aw-1:0] hi_addr, lo_addr, sel_addr;

  // Descending scan leaves the lowest set bit above last_q in hi_*, lowest overall in lo_*;
  // preferring hi_* gives a search that starts at last+1 and wraps.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_addr  = '0;
    lo_addr  = '0;
    for (int i = int'(NReq) - 1; i >= 0; i--) begin
      if (bus_io.req[i]) begin
        any_req = 1'b1;
        lo_idx  = 3'(i);
        lo_addr = bus_io.req_addr[i*Aw +: Aw];
        if (3'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
          hi_addr  = bus_io.req_addr[i*Aw +: Aw];
        end
      end
    end
  end

  assign sel_idx  = hi_found ? hi_idx : lo_idx;
  assign sel_addr = hi_found ? hi_addr : lo_addr;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    ack_d     = '0;
    ack_err_d = 1'b0;
    to_cnt_d  = to_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.enable && any_req && !bus_io.tx_mac_done) begin
          grant_d = sel_idx;
          addr_d  = sel_addr;
          wd_d    = '0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (bus_io.tx_mac_done) begin
          ack_d   = {{(NReq-1){1'b0}}, 1'b1} << grant_q;
          last_d  = grant_q;
          state_d = StRelease;
        end else if (&wd_q) begin
          ack_d     = {{(NReq-1){1'b0}}, 1'b1} << grant_q;
          ack_err_d = 1'b1;
          last_d    = grant_q;
          if (to_cnt_q != 8'hff) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
          state_d = StRelease;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StRelease: begin
        if (!bus_io.tx_mac_done) begin
          if (Gap == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (32'(gap_q) + 32'd1 >= Gap) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= 3'(NReq - 1);
      addr_q    <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Start and busy decode straight from the state register so reset clears them at once.
  assign bus_io.tx_mac_start   = (state_q == StLaunch);
  assign bus_io.busy           = (state_q != StIdle);
  assign bus_io.ack            = ack_q;
  assign bus_io.ack_err        = ack_err_q;
  assign bus_io.buf_start_addr = addr_q;
  assign bus_io.cur_grant      = grant_q;
  assign bus_io.timeout_count  = to_cnt_q;

endmodule

// File: tb/tb_tx_mac_sched.sv
// Bench for tx_mac_sched: vector table, directed corner sequences and a randomized run
// scored against a round-robin reference model.
module tb_tx_mac_sched;
  localparam int unsigned NReq = 4;
  localparam int unsigned Aw   = 10;
  localparam int unsigned Gap  = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [9:0] addr_tab [4] = '{10'h040, 10'h155, 10'h2AA, 10'h3FF};

  tx_mac_sched_if #(.NReq(NReq), .Aw(Aw)) bi ();
  tx_mac_sched_if #(.NReq(NReq), .Aw(Aw)) bt ();

  tx_mac_sched #(.NReq(NReq), .Aw(Aw), .ToBits(16), .Gap(Gap)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bi)
  );

  tx_mac_sched #(.NReq(NReq), .Aw(Aw), .ToBits(4), .Gap(Gap)) u_dut_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       done;
    logic       s;
    logic       b;
    logic [3:0] ack;
    logic       err;
    logic [2:0] g;
    logic [9:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [3:0] rq, input logic dn,
                              input logic s, input logic b, input logic [3:0] a,
                              input logic e, input logic [2:0] g, input logic [9:0] ad);
    vec_t v;
    v.en = en; v.req = rq; v.done = dn; v.s = s; v.b = b;
    v.ack = a; v.err = e; v.g = g; v.addr = ad;
    return v;
  endfunction

  // First requester at or after last+1, wrapping; -1 when nothing is requested.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bi.req = '0; bi.enable = 1'b1; bi.tx_mac_done = 1'b0;
    bt.req = '0; bt.enable = 1'b1; bt.tx_mac_done = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step;
  endtask

  // Waits for a launch on bi, raises done delay cycles after start rose, returns ack sample.
  task automatic run_txn(input int delay, input bit keep_done, output int wait_n,
                         output int start_n, output logic [3:0] ack, output logic err,
                         output logic [2:0] grant, output logic [9:0] addr);
    wait_n = 0;
    while (!bi.tx_mac_start && wait_n < 300) begin
      step;
      wait_n++;
    end
    if (!bi.tx_mac_start) chk("start_wait_expired", 32'(bi.tx_mac_start), 32'd1);
    grant = bi.cur_grant;
    addr  = bi.buf_start_addr;
    start_n = 0;
    while (bi.tx_mac_start && start_n < 300) begin
      start_n++;
      if (start_n == delay + 1) bi.tx_mac_done = 1'b1;
      step;
    end
    ack = bi.ack;
    err = bi.ack_err;
    if (!keep_done) bi.tx_mac_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int         wait_n, start_n, n, errs, bad, sel, last_m;
    logic [3:0] ack, pending;
    logic       err;
    logic [2:0] grant;
    logic [9:0] addr;
    logic [19:0] act, exp;

    bi.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    bt.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    do_reset;

    chk("rst_start", 32'(bi.tx_mac_start), 32'd0);
    chk("rst_busy", 32'(bi.busy), 32'd0);
    chk("rst_ack", 32'(bi.ack), 32'd0);
    chk("rst_ack_err", 32'(bi.ack_err), 32'd0);
    chk("rst_addr", 32'(bi.buf_start_addr), 32'd0);
    chk("rst_grant", 32'(bi.cur_grant), 32'd0);
    chk("rst_tcount", 32'(bi.timeout_count), 32'd0);

    // Cycle table: en, req, done | start, busy, ack, err, grant, addr
    vecs.push_back(mk(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 3'd0, 10'h000));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0000, 0, 3'd0, 10'h000));
    vecs.push_back(mk(1, 4'b0100, 0, 1, 1, 4'b0000, 0, 3'd2, 10'h2AA));
    vecs.push_back(mk(1, 4'b0100, 0, 1, 1, 4'b0000, 0, 3'd2, 10'h2AA));
    vecs.push_back(mk(1, 4'b0100, 1, 0, 1, 4'b0100, 0, 3'd2, 10'h2AA));
    vecs.push_back(mk(1, 4'b0000, 1, 0, 1, 4'b0000, 0, 3'd2, 10'h2AA));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 3'd2, 10'h2AA));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 3'd2, 10'h2AA));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 4'b0000, 0, 3'd2, 10'h2AA));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 3'd2, 10'h2AA));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 1, 4'b0000, 0, 3'd0, 10'h040));
    vecs.push_back(mk(1, 4'b0001, 0, 1, 1, 4'b0000, 0, 3'd0, 10'h040));
    vecs.push_back(mk(1, 4'b0001, 1, 0, 1, 4'b0001, 0, 3'd0, 10'h040));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 3'd0, 10'h040));
    for (int r = 0; r < vecs.size(); r++) begin
      bi.enable = vecs[r].en;
      bi.req = vecs[r].req;
      bi.tx_mac_done = vecs[r].done;
      step;
      act = {bi.tx_mac_start, bi.busy, bi.ack, bi.ack_err, bi.cur_grant, bi.buf_start_addr};
      exp = {vecs[r].s, vecs[r].b, vecs[r].ack, vecs[r].err, vecs[r].g, vecs[r].addr};
      chk($sformatf("vec%0d", r), 32'(act), 32'(exp));
    end

    // Single launch: done 20 cycles after start, then RELEASE + 8 GAP cycles.
    do_reset;
    bi.req = 4'b0001;
    run_txn(20, 0, wait_n, start_n, ack, err, grant, addr);
    chk("single_wait", 32'(wait_n), 32'd1);
    chk("single_addr", 32'(addr), 32'h040);
    chk("single_start_len", 32'(start_n), 32'd21);
    chk("single_ack", 32'(ack), 32'd1);
    chk("single_err", 32'(err), 32'd0);
    n = 1;
    step;
    chk("single_ack_pulse", 32'(bi.ack), 32'd0);
    bi.req = 4'b0000;
    if (bi.busy) n++;
    while (bi.busy && n < 50) begin
      step;
      if (bi.busy) n++;
    end
    chk("single_busy_after_ack", 32'(n), 32'd9);

    // Round-robin with all sources requesting continuously.
    do_reset;
    bi.req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      run_txn(2, 0, wait_n, start_n, ack, err, grant, addr);
      chk($sformatf("rr_grant%0d", t), 32'(grant), 32'(t % 4));
      chk($sformatf("rr_ack%0d", t), 32'(ack), 32'(1 << (t % 4)));
    end
    bi.req = 4'b0000;

    // Watchdog on the 4-bit instance: done never arrives.
    do_reset;
    bt.req = 4'b0001;
    n = 0;
    while (!bt.tx_mac_start && n < 20) begin step; n++; end
    n = 0;
    while (bt.tx_mac_start && n < 100) begin step; n++; end
    chk("to_start_len", 32'(n), 32'd16);
    chk("to_err", 32'(bt.ack_err), 32'd1);
    chk("to_ack", 32'(bt.ack), 32'd1);
    chk("to_count1", 32'(bt.timeout_count), 32'd1);
    errs = 1;
    n = 0;
    while (errs < 300 && n < 20000) begin
      step;
      n++;
      if (bt.ack_err) begin
        errs++;
        if (errs == 2) chk("to_count2", 32'(bt.timeout_count), 32'd2);
      end
    end
    chk("to_err_pulses", 32'(errs), 32'd300);
    chk("to_count_sat", 32'(bt.timeout_count), 32'd255);
    bt.req = 4'b0000;

    // Done stuck high for 50 cycles after the ack.
    do_reset;
    bi.req = 4'b0011;
    run_txn(3, 1, wait_n, start_n, ack, err, grant, addr);
    chk("stuck_ack", 32'(ack), 32'd1);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step;
      if (k == 0) bi.req = 4'b0010;
      if (bi.tx_mac_start || !bi.busy) bad++;
    end
    chk("stuck_hold", 32'(bad), 32'd0);
    bi.tx_mac_done = 1'b0;
    run_txn(2, 0, wait_n, start_n, ack, err, grant, addr);
    chk("stuck_relaunch_wait", 32'(wait_n), 32'd10);
    chk("stuck_relaunch_grant", 32'(grant), 32'd1);
    bi.req = 4'b0000;

    // Enable dropped mid-launch; pending source launches one cycle after enable returns.
    do_reset;
    bi.req = 4'b0001;
    n = 0;
    while (!bi.tx_mac_start && n < 20) begin step; n++; end
    step;
    bi.enable = 1'b0;
    bi.req = 4'b0011;
    step;
    bi.tx_mac_done = 1'b1;
    step;
    chk("en_ack", 32'(bi.ack), 32'd1);
    bi.tx_mac_done = 1'b0;
    step;
    bi.req = 4'b0010;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step;
      if (bi.tx_mac_start) n++;
    end
    chk("en_blocked", 32'(n), 32'd0);
    bi.enable = 1'b1;
    step;
    chk("en_relaunch", 32'(bi.tx_mac_start), 32'd1);
    chk("en_grant", 32'(bi.cur_grant), 32'd1);
    bi.tx_mac_done = 1'b1;
    step;
    chk("en_ack2", 32'(bi.ack), 32'd2);
    bi.tx_mac_done = 1'b0;
    bi.req = 4'b0000;
    repeat (15) step;
    // Done already high in IDLE blocks a launch until it falls.
    bi.tx_mac_done = 1'b1;
    bi.req = 4'b0100;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      step;
      if (bi.tx_mac_start) n++;
    end
    chk("done_high_idle", 32'(n), 32'd0);
    bi.tx_mac_done = 1'b0;
    step;
    chk("done_low_launch", 32'(bi.tx_mac_start), 32'd1);
    chk("done_low_grant", 32'(bi.cur_grant), 32'd2);

    // Reset asserted mid-launch: outputs clear without a clock, no ack, source 0 first after.
    do_reset;
    bi.req = 4'b0100;
    n = 0;
    while (!bi.tx_mac_start && n < 20) begin step; n++; end
    step;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_start", 32'(bi.tx_mac_start), 32'd0);
    chk("rstmid_busy", 32'(bi.busy), 32'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step;
      if (bi.ack != 4'b0000) bad++;
    end
    chk("rstmid_no_ack", 32'(bad), 32'd0);
    bi.req = 4'b0111;
    rst_n = 1'b1;
    run_txn(1, 0, wait_n, start_n, ack, err, grant, addr);
    chk("rstmid_wait", 32'(wait_n), 32'd1);
    chk("rstmid_grant", 32'(grant), 32'd0);
    bi.req = 4'b0000;

    // Randomized traffic against the round-robin reference model.
    do_reset;
    last_m = 3;
    pending = 4'($urandom_range(1, 15));
    bi.req = pending;
    for (int it = 0; it < 40; it++) begin
      int delay;
      sel = rr_pick(pending, last_m);
      delay = int'($urandom_range(0, 12));
      run_txn(delay, 0, wait_n, start_n, ack, err, grant, addr);
      chk($sformatf("rnd%0d_wait", it), 32'(wait_n), (it == 0) ? 32'd1 : 32'(Gap + 1));
      chk($sformatf("rnd%0d_grant", it), 32'(grant), 32'(sel));
      chk($sformatf("rnd%0d_addr", it), 32'(addr), 32'(addr_tab[sel]));
      chk($sformatf("rnd%0d_len", it), 32'(start_n), 32'(delay + 1));
      chk($sformatf("rnd%0d_ack", it), 32'(ack), 32'(1 << sel));
      chk($sformatf("rnd%0d_err", it), 32'(err), 32'd0);
      last_m = sel;
      pending[sel] = 1'b0;
      pending = pending | 4'($urandom_range(0, 15));
      if (pending == 4'b0000) pending[$urandom_range(0, 3)] = 1'b1;
      step;
      bi.req = pending;
    end
    bi.req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
